// File: rtl/core_ifetch_pkg.sv
// core_ifetch_pkg: fetch FSM state encodings and the reset NOP word
package core_ifetch_pkg;
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/core_ifetch.sv
// core_ifetch: single-outstanding instruction fetch with redirect and misalign halt
module core_ifetch
    import core_ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_ARVALID,
    input  logic        IMEM_ARREADY,
    output logic [31:0] IMEM_ARADDR,
    input  logic        IMEM_RVALID,
    output logic        IMEM_RREADY,
    input  logic [31:0] IMEM_RDATA,
    output logic        IF_VALID,
    input  logic        ID_READY,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] IF_PC,
    input  logic        C_REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IF_MISALIGN
);
    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        pend;
    logic        redir_bad;
    logic        redir_ok;
    logic        halt;
    logic        r_hs;

    assign redir_bad    = C_REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
    assign redir_ok     = C_REDIRECT && !redir_bad;
    assign halt         = IF_MISALIGN || redir_bad;
    assign r_hs         = IMEM_RVALID && IMEM_RREADY;
    assign IMEM_ARVALID = (state == S_REQ) && !RST;
    assign IMEM_ARADDR  = pc;
    assign IMEM_RREADY  = (state == S_WAIT) && !RST;
    assign IF_VALID     = (state == S_HOLD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_REQ;
            pc          <= RESET_VECTOR;
            pend        <= 1'b0;
            pend_pc     <= RESET_VECTOR;
            IF_MISALIGN <= 1'b0;
            INSTRUCTION <= NOP;
            IF_PC       <= RESET_VECTOR;
        end else begin
            if (redir_bad)
                IF_MISALIGN <= 1'b1;
            case (state)
                S_REQ: begin
                    // the address stays presented; the redirect waits for its response
                    if (redir_ok) begin
                        pend    <= 1'b1;
                        pend_pc <= REDIRECT_PC;
                    end
                    if (IMEM_ARREADY)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_hs) begin
                        pend <= 1'b0;
                        if (halt)
                            state <= S_HALT;
                        else if (redir_ok || pend) begin
                            pc    <= redir_ok ? REDIRECT_PC : pend_pc;
                            state <= S_REQ;
                        end else begin
                            INSTRUCTION <= IMEM_RDATA;
                            IF_PC       <= pc;
                            state       <= S_HOLD;
                        end
                    end else if (redir_ok) begin
                        pend    <= 1'b1;
                        pend_pc <= REDIRECT_PC;
                    end
                end
                S_HOLD: begin
                    if (halt)
                        state <= S_HALT;
                    else if (redir_ok) begin
                        pc    <= REDIRECT_PC;
                        state <= S_REQ;
                    end else if (ID_READY) begin
                        pc    <= IF_PC + 32'd4;
                        state <= S_REQ;
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_core_ifetch.sv
// tb_core_ifetch: directed and randomized checks of core_ifetch against a program-order model
module tb_core_ifetch;
    logic        CLK = 1'b0;
    logic        RST;
    logic        IMEM_ARVALID;
    logic        IMEM_ARREADY;
    logic [31:0] IMEM_ARADDR;
    logic        IMEM_RVALID;
    logic        IMEM_RREADY;
    logic [31:0] IMEM_RDATA;
    logic        IF_VALID;
    logic        ID_READY;
    logic [31:0] INSTRUCTION;
    logic [31:0] IF_PC;
    logic        C_REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IF_MISALIGN;

    core_ifetch dut (
        .CLK(CLK), .RST(RST),
        .IMEM_ARVALID(IMEM_ARVALID), .IMEM_ARREADY(IMEM_ARREADY), .IMEM_ARADDR(IMEM_ARADDR),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RREADY(IMEM_RREADY), .IMEM_RDATA(IMEM_RDATA),
        .IF_VALID(IF_VALID), .ID_READY(ID_READY), .INSTRUCTION(INSTRUCTION), .IF_PC(IF_PC),
        .C_REDIRECT(C_REDIRECT), .REDIRECT_PC(REDIRECT_PC), .IF_MISALIGN(IF_MISALIGN)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    // memory model: one response slot, fixed latency, optional spurious RVALID when idle
    bit          busy = 1'b0;
    logic [31:0] mem_addr = '0;
    int          cnt = 0;
    int          lat = 0;
    int          ardy_mode = 1;
    bit          spur = 1'b0;
    // program-order model: the next PC that decode must receive
    logic [31:0] exp_pc = '0;
    int          deliveries = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : ({a[15:0], a[31:16]} ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        bit ar_hs, r_hs, stall, ar_hold, redir;
        logic [31:0] s_instr, s_pc, s_addr;
        IMEM_ARREADY = (ardy_mode == 2) ? 1'($urandom_range(0, 1)) : (ardy_mode == 1);
        IMEM_RVALID  = busy ? (cnt == 0) : (spur && $urandom_range(0, 1) == 1);
        IMEM_RDATA   = (busy && cnt == 0) ? memf(mem_addr) : $urandom;
        #1;
        ar_hs   = IMEM_ARVALID && IMEM_ARREADY;
        r_hs    = IMEM_RVALID && IMEM_RREADY;
        redir   = C_REDIRECT && !RST;
        if (ar_hs) begin
            chk("one_outstanding", 32'(busy), 32'd0);
            chk("araddr_align", 32'(IMEM_ARADDR[1:0]), 32'd0);
        end
        if (IF_VALID && ID_READY && !redir && !RST) begin
            chk("deliver_pc", IF_PC, exp_pc);
            chk("deliver_instr", INSTRUCTION, memf(exp_pc));
            exp_pc += 32'd4;
            deliveries++;
        end
        if (redir)
            exp_pc = REDIRECT_PC;
        stall   = IF_VALID && !ID_READY && !redir && !RST;
        ar_hold = IMEM_ARVALID && !IMEM_ARREADY && !RST;
        s_instr = INSTRUCTION;
        s_pc    = IF_PC;
        s_addr  = IMEM_ARADDR;
        @(posedge CLK);
        if (ar_hs) begin
            busy = 1'b1;
            mem_addr = s_addr;
            cnt = lat;
        end else if (r_hs)
            busy = 1'b0;
        else if (busy && cnt > 0)
            cnt--;
        @(negedge CLK);
        #1;
        if (stall && !RST) begin
            chk("stall_valid", 32'(IF_VALID), 32'd1);
            chk("stall_instr", INSTRUCTION, s_instr);
            chk("stall_pc", IF_PC, s_pc);
        end
        if (ar_hold && !RST) begin
            chk("ar_hold_valid", 32'(IMEM_ARVALID), 32'd1);
            chk("ar_hold_addr", IMEM_ARADDR, s_addr);
        end
        if (redir && !RST)
            chk("redirect_kills_valid", 32'(IF_VALID), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1);
    end

    initial begin
        int n, dv0, arc;
        logic [31:0] r;
        RST = 1'b1;
        ID_READY = 1'b0;
        C_REDIRECT = 1'b0;
        REDIRECT_PC = '0;
        IMEM_ARREADY = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA = '0;
        @(negedge CLK);
        tick();
        tick();
        chk("rst_arvalid", 32'(IMEM_ARVALID), 32'd0);
        chk("rst_rready", 32'(IMEM_RREADY), 32'd0);
        chk("rst_if_valid", 32'(IF_VALID), 32'd0);
        chk("rst_instr", INSTRUCTION, 32'h0000_0013);
        chk("rst_if_pc", IF_PC, 32'h0);
        chk("rst_misalign", 32'(IF_MISALIGN), 32'd0);
        RST = 1'b0;
        #1;
        chk("first_arvalid", 32'(IMEM_ARVALID), 32'd1);
        chk("first_araddr", IMEM_ARADDR, 32'h0);

        // zero-wait fetch, then a five-cycle decode stall
        tick();
        chk("wait_rready", 32'(IMEM_RREADY), 32'd1);
        chk("wait_if_valid", 32'(IF_VALID), 32'd0);
        tick();
        chk("hold_if_valid", 32'(IF_VALID), 32'd1);
        chk("hold_instr", INSTRUCTION, 32'h0050_0093);
        chk("hold_if_pc", IF_PC, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_no_arvalid", 32'(IMEM_ARVALID), 32'd0);
        end
        ID_READY = 1'b1;
        tick();
        ID_READY = 1'b0;
        chk("next_arvalid", 32'(IMEM_ARVALID), 32'd1);
        chk("next_araddr", IMEM_ARADDR, 32'h4);

        // redirect while waiting; late response dropped
        lat = 3;
        tick();
        C_REDIRECT = 1'b1;
        REDIRECT_PC = 32'h100;
        tick();
        C_REDIRECT = 1'b0;
        n = 0;
        while (!IMEM_ARVALID && n < 10) begin
            chk("drop_if_valid", 32'(IF_VALID), 32'd0);
            tick();
            n++;
        end
        chk("redir_wait_arvalid", 32'(IMEM_ARVALID), 32'd1);
        chk("redir_wait_araddr", IMEM_ARADDR, 32'h100);

        // redirect coincident with decode accept in hold
        lat = 0;
        tick();
        tick();
        chk("hold100_valid", 32'(IF_VALID), 32'd1);
        chk("hold100_pc", IF_PC, 32'h100);
        dv0 = deliveries;
        C_REDIRECT = 1'b1;
        REDIRECT_PC = 32'h40;
        ID_READY = 1'b1;
        tick();
        C_REDIRECT = 1'b0;
        ID_READY = 1'b0;
        chk("redir_hold_no_deliver", 32'(deliveries), 32'(dv0));
        chk("redir_hold_araddr", IMEM_ARADDR, 32'h40);

        // redirect while the request is presented, to the last word before wrap
        C_REDIRECT = 1'b1;
        REDIRECT_PC = 32'hFFFF_FFFC;
        tick();
        C_REDIRECT = 1'b0;
        n = 0;
        while (!IF_VALID && n < 10) begin
            tick();
            n++;
        end
        chk("wrap_hold_pc", IF_PC, 32'hFFFF_FFFC);
        ID_READY = 1'b1;
        tick();
        ID_READY = 1'b0;
        chk("wrap_araddr", IMEM_ARADDR, 32'h0);

        // reset mid-transaction; stale RVALID afterwards ignored
        lat = 3;
        tick();
        ardy_mode = 0;
        RST = 1'b1;
        tick();
        chk("midrst_arvalid", 32'(IMEM_ARVALID), 32'd0);
        chk("midrst_rready", 32'(IMEM_RREADY), 32'd0);
        RST = 1'b0;
        busy = 1'b0;
        spur = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stale_rready", 32'(IMEM_RREADY), 32'd0);
            chk("stale_if_valid", 32'(IF_VALID), 32'd0);
        end
        chk("stale_araddr", IMEM_ARADDR, 32'h0);
        chk("stale_instr", INSTRUCTION, 32'h0000_0013);

        // randomized traffic
        ardy_mode = 2;
        dv0 = deliveries;
        for (int i = 0; i < 3000; i++) begin
            lat = int'($urandom_range(0, 3));
            ID_READY = ($urandom_range(0, 9) < 7);
            C_REDIRECT = ($urandom_range(0, 15) == 0);
            r = $urandom;
            REDIRECT_PC = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | (r & 32'hC)) : (r & 32'hFFFF_FFFC);
            tick();
        end
        C_REDIRECT = 1'b0;
        chk("random_progress", 32'(deliveries - dv0 > 50), 32'd1);

        // misaligned redirect halts until reset
        ardy_mode = 1;
        C_REDIRECT = 1'b1;
        REDIRECT_PC = 32'h102;
        tick();
        C_REDIRECT = 1'b0;
        chk("misalign_set", 32'(IF_MISALIGN), 32'd1);
        chk("misalign_if_valid", 32'(IF_VALID), 32'd0);
        arc = 0;
        for (int i = 0; i < 12; i++) begin
            ID_READY = 1'($urandom_range(0, 1));
            tick();
            if (IMEM_ARVALID || IF_VALID) arc++;
        end
        chk("halt_no_activity", 32'(arc), 32'd0);
        chk("halt_rready", 32'(IMEM_RREADY), 32'd0);
        chk("halt_misalign_sticky", 32'(IF_MISALIGN), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        busy = 1'b0;
        exp_pc = 32'h0;
        #1;
        chk("exit_misalign", 32'(IF_MISALIGN), 32'd0);
        chk("exit_arvalid", 32'(IMEM_ARVALID), 32'd1);
        chk("exit_araddr", IMEM_ARADDR, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
